// File: rtl/ctrl_update_queue.sv
// Circular queue of resolved control-transfer outcomes feeding predictor/BTB training; one-cycle push-to-head latency.
// Head is held under !updReady_i; arrivals that find the queue full (and no pop that cycle) are dropped and counted.
module ctrl_update_queue #(
    parameter int DEPTH           = 4,
    parameter int CNT_W           = 8,
    parameter int SIZE_PC         = 32,
    parameter int BRANCH_TYPE_LOG = 2,
    parameter int SIZE_CTI_LOG    = 4,
    localparam int PTR_W          = $clog2(DEPTH),
    localparam int OCC_W          = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exceptionFlag_i,
    input  logic                       exeCtrlValid_i,
    input  logic [SIZE_PC-1:0]         exeCtrlPC_i,
    input  logic [BRANCH_TYPE_LOG-1:0] exeCtrlType_i,
    input  logic [SIZE_PC-1:0]         exeCtrlNPC_i,
    input  logic                       exeCtrlDir_i,
    input  logic [SIZE_CTI_LOG-1:0]    exeCtiID_i,
    output logic                       updValid_o,
    output logic [SIZE_PC-1:0]         updPC_o,
    output logic [BRANCH_TYPE_LOG-1:0] updType_o,
    output logic [SIZE_PC-1:0]         updNPC_o,
    output logic                       updDir_o,
    output logic [SIZE_CTI_LOG-1:0]    updCtiID_o,
    input  logic                       updReady_i,
    output logic [OCC_W-1:0]           occupancy_o,
    output logic                       full_o,
    output logic [CNT_W-1:0]           dropCnt_o
);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef struct packed {
        logic [SIZE_PC-1:0]         pc;
        logic [BRANCH_TYPE_LOG-1:0] br_type;
        logic [SIZE_PC-1:0]         npc;
        logic                       dir;
        logic [SIZE_CTI_LOG-1:0]    cti_id;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head_dat;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   drop_cnt;
    logic               pop;
    logic               push;
    logic               drop;

    assign full_o     = (occ == OCC_FULL);
    assign updValid_o = (occ != '0);
    assign pop        = updValid_o & updReady_i;
    // A pop frees the slot this edge, so a full queue still accepts a same-cycle arrival.
    assign push       = exeCtrlValid_i & (~full_o | pop);
    assign drop       = exeCtrlValid_i & full_o & ~pop;

    always_ff @(posedge clk) begin
        if (push && !exceptionFlag_i) begin
            mem[tail] <= '{pc: exeCtrlPC_i, br_type: exeCtrlType_i, npc: exeCtrlNPC_i,
                           dir: exeCtrlDir_i, cti_id: exeCtiID_i};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            drop_cnt <= '0;
        end else if (exceptionFlag_i) begin
            // Flush discards entries but keeps the drop statistic.
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign head_dat    = updValid_o ? mem[head] : '0;
    assign updPC_o     = head_dat.pc;
    assign updType_o   = head_dat.br_type;
    assign updNPC_o    = head_dat.npc;
    assign updDir_o    = head_dat.dir;
    assign updCtiID_o  = head_dat.cti_id;
    assign occupancy_o = occ;
    assign dropCnt_o   = drop_cnt;
endmodule
